// File: rtl/mips_div_unit.sv
// mips_div_unit: iterative restoring divider for the execute stage.
// Produces Lo = quotient and Hi = remainder, one quotient bit per cycle,
// with optional two's-complement operands (truncating division).
module mips_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sign,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_a_raw;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dz_out;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic             w_qbit;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;

  // Operand magnitudes; |most-negative| wraps to itself, which the unsigned datapath handles.
  always_comb begin
    w_a_neg = i_sign & i_a[WIDTH-1];
    w_b_neg = i_sign & i_b[WIDTH-1];
    if (w_a_neg) begin
      w_a_mag = -i_a;
    end else begin
      w_a_mag = i_a;
    end
    if (w_b_neg) begin
      w_b_mag = -i_b;
    end else begin
      w_b_mag = i_b;
    end
  end

  // One restoring step: shift in the next dividend bit and try to subtract the divisor.
  always_comb begin
    w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, r_div};
    if (!w_trial[WIDTH]) begin
      w_rem_nx = w_trial[WIDTH-1:0];
      w_qbit   = 1'b1;
    end else begin
      w_rem_nx = w_rem_sh[WIDTH-1:0];
      w_qbit   = 1'b0;
    end
    w_quo_nx = {r_quo[WIDTH-2:0], w_qbit};
  end

  // Sign correction applied in the FIX cycle.
  always_comb begin
    if (r_neg_q) begin
      w_lo_fix = -r_quo;
    end else begin
      w_lo_fix = r_quo;
    end
    if (r_neg_r) begin
      w_hi_fix = -r_rem;
    end else begin
      w_hi_fix = r_rem;
    end
  end

  // Control FSM plus datapath and registered result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_rem    <= {WIDTH{1'b0}};
      r_quo    <= {WIDTH{1'b0}};
      r_div    <= {WIDTH{1'b0}};
      r_a_raw  <= {WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_dz_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rem   <= {WIDTH{1'b0}};
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_a_raw <= i_a;
            r_cnt   <= CW'(WIDTH);
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_busy  <= 1'b1;
            if (i_b == {WIDTH{1'b0}}) begin
              r_dz    <= 1'b1;
              r_state <= S_FIX;
            end else begin
              r_dz    <= 1'b0;
              r_state <= S_RUN;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_FIX: begin
          if (r_dz) begin
            r_lo     <= {WIDTH{1'b1}};
            r_hi     <= r_a_raw;
            r_dz_out <= 1'b1;
          end else begin
            r_lo     <= w_lo_fix;
            r_hi     <= w_hi_fix;
            r_dz_out <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_div_zero = r_dz_out;

endmodule

// File: tb/tb_mips_div_unit.sv
// Directed testbench for mips_div_unit (WIDTH = 32).
module tb_mips_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sign;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dz;

  int total = 0;
  int bad   = 0;

  mips_div_unit #(.WIDTH(32)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_a        (a),
    .i_b        (b),
    .i_sign     (sign),
    .o_busy     (busy),
    .o_done     (done),
    .o_hi       (hi),
    .o_lo       (lo),
    .o_div_zero (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a request, let one posedge sample it, drop Start.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    a     = ta;
    b     = tb;
    sign  = ts;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the accept edge (n0 cycles already elapsed).
  task automatic run_check(input string tag, input int n0, input int exp_lat,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input logic exp_dz);
    int   n;
    logic busy_ok;
    n       = n0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"},  n, exp_lat);
    chk({tag, "_busyhold"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
    chk({tag, "_lo"},   lo, exp_lo);
    chk({tag, "_hi"},   hi, exp_hi);
    chk({tag, "_dz"},   {31'd0, dz}, {31'd0, exp_dz});
  endtask

  task automatic done_low(input string tag);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    clk   = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    sign  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi",   hi, 32'd0);
    chk("rst_lo",   lo, 32'd0);
    chk("rst_dz",   {31'd0, dz}, 32'd0);

    // Unsigned 100 / 7.
    issue(32'd100, 32'd7, 1'b0);
    run_check("u100d7", 0, 33, 32'd14, 32'd2, 1'b0);
    done_low("u100d7");

    // Signed -7 / 2 then the same bits unsigned.
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_check("s_m7d2", 0, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    done_low("s_m7d2");
    issue(32'hFFFF_FFF9, 32'd2, 1'b0);
    run_check("u_m7d2", 0, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);
    done_low("u_m7d2");

    // Divide by zero, unsigned and signed (Hi is the raw dividend).
    issue(32'd5, 32'd0, 1'b0);
    run_check("dz5", 0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1);
    done_low("dz5");
    issue(32'hFFFF_FFFB, 32'd0, 1'b1);
    run_check("dzm5", 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    done_low("dzm5");

    // Signed overflow; results are not cleared by Start.
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("hold_dz_on_start", {31'd0, dz}, 32'd1);
    chk("hold_lo_on_start", lo, 32'hFFFF_FFFF);
    run_check("ovf", 0, 33, 32'h8000_0000, 32'd0, 1'b0);
    done_low("ovf");

    // Unsigned all-ones / 1.
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_check("uffd1", 0, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);
    done_low("uffd1");

    // 40 / 6 with Start held, then 9 / 3 presented mid-run (ignored).
    a     = 32'd40;
    b     = 32'd6;
    sign  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        a = 32'd9;
        b = 32'd3;
      end
      @(negedge clk);
    end
    start = 1'b0;
    run_check("held40d6", 6, 33, 32'd6, 32'd4, 1'b0);
    // Start 9 / 3 in the Done cycle.
    issue(32'd9, 32'd3, 1'b0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done0", {31'd0, done}, 32'd0);
    run_check("b2b9d3", 0, 33, 32'd3, 32'd0, 1'b0);
    done_low("b2b9d3");

    // Make the outputs non-zero, then reset mid-run.
    issue(32'd7, 32'd0, 1'b0);
    run_check("dz7", 0, 1, 32'hFFFF_FFFF, 32'd7, 1'b1);
    done_low("dz7");
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_hi",   hi, 32'd0);
    chk("mrst_lo",   lo, 32'd0);
    chk("mrst_dz",   {31'd0, dz}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("mrst_nodone", ndone, 32'd0);
    issue(32'd100, 32'd7, 1'b0);
    run_check("post_rst", 0, 33, 32'd14, 32'd2, 1'b0);
    done_low("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_div_unit.md
Name: mips_div_unit

Overview:
- Iterative multi-cycle integer divider. Produces Hi (remainder) and Lo (quotient), matching the Hi/Lo result convention of the ALU multiply path.
- Sits beside the ALU in the execute stage. Control issues Start and stalls on Busy until Done pulses.
- Uses a restoring algorithm, one quotient bit per cycle, with a signed/unsigned mode selected by Sign.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  request a division; sampled on edges where Busy is 0.
- A  input  WIDTH  dividend; captured when Start is accepted.
- B  input  WIDTH  divisor; captured when Start is accepted.
- Sign  input  1  1 = two's-complement operands, 0 = unsigned; captured with A and B.
- Busy  output  1  division in progress; new Start is ignored.
- Done  output  1  one-cycle pulse: Hi, Lo and DivZero are valid.
- Hi  output  WIDTH  remainder.
- Lo  output  WIDTH  quotient.
- DivZero  output  1  last completed operation had B == 0.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - State goes to IDLE.
  - Busy = 0, Done = 0, Hi = 0, Lo = 0, DivZero = 0.
  - Any in-flight operation is aborted with no Done pulse.
  - rst overrides Start in the same cycle.
- States: IDLE, RUN, FIX.
- Accept:
  - Condition: Start = 1 and Busy = 0 at edge E0. Busy = 0 in IDLE and in the Done cycle, so back-to-back Start in the Done cycle is accepted.
  - At E0, capture Sign.
  - Operand magnitudes: Sign = 1 uses |A| and |B|, computed in WIDTH-bit unsigned arithmetic (|0x80000000| = 0x80000000). Sign = 0 uses the raw values.
  - At E0, record the quotient sign (A[MSB] ^ B[MSB]) and remainder sign (A[MSB]), both qualified by Sign.
  - Load the remainder register to 0 and the counter to WIDTH.
  - Next state is RUN (B != 0) or FIX with the divide-by-zero flag set (B == 0).
  - Busy = 1 from E0.
- RUN, one step per edge:
  - Shift {rem, quo} left by 1 and form trial = rem - divisor at WIDTH+1 bits.
  - If trial is non-negative, rem = trial and quo LSB = 1; otherwise restore and quo LSB = 0.
  - Decrement the counter. At the step where it reaches 0, go to FIX.
  - Exactly WIDTH RUN edges (E1..EWIDTH).
- FIX, one edge:
  - Lo = quotient, negated if the quotient sign is set.
  - Hi = remainder, negated if the remainder sign is set.
  - DivZero = 0. Done = 1 for one cycle, Busy = 0, state goes to IDLE.
- Divide by zero:
  - FIX at E1 writes Lo = all ones, Hi = A as captured (raw, unmodified), DivZero = 1.
  - Done appears after E1 (latency 1 cycle).
- Normal latency:
  - Done is asserted after edge E(WIDTH+1), i.e. WIDTH+1 cycles after accept.
  - Busy is high for exactly WIDTH+1 cycles.
- Signed overflow: A = most negative, B = -1 gives Lo = 0x80000000, Hi = 0. No flag.
- Hi, Lo and DivZero hold their values until the next FIX or reset. They are not cleared on Start.
- Start while Busy = 1 is ignored and has no effect on the operation in flight.
- Truncating division: the quotient rounds toward zero and the remainder has the sign of the dividend.
- Output registers: Done, Busy, Hi, Lo and DivZero are all registered. There is no combinational path from any input to any output.

Test Plan:
- Unsigned 100 / 7, Sign = 0, Start one cycle -> Busy for 33 cycles, then Done pulse of exactly 1 cycle with Lo = 14, Hi = 2, DivZero = 0.
- Signed -7 / 2 (A = 0xFFFFFFF9, B = 2, Sign = 1) -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF. Repeat with Sign = 0 -> Lo = 0x7FFFFFFC, Hi = 1.
- Divide by zero, A = 5, B = 0 -> Done 1 cycle after accept with DivZero = 1, Lo = 0xFFFFFFFF, Hi = 5. The next valid divide clears DivZero.
- Signed 0x80000000 / 0xFFFFFFFF -> Lo = 0x80000000, Hi = 0. Unsigned 0xFFFFFFFF / 1 -> Lo = 0xFFFFFFFF, Hi = 0.
- Start 40 / 6 held, then pulse Start with 9 / 3 mid-run -> the mid-run Start is ignored and the result is Lo = 6, Hi = 4. Start 9 / 3 in the Done cycle -> accepted, and 33 cycles later Lo = 3, Hi = 0.
- rst asserted at cycle 10 of a run -> Busy = 0, Done never pulses, and Hi = Lo = DivZero = 0. A fresh Start after release completes normally.
